// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store alignment unit.
//   - funct3 encodings for RV32I loads and stores
//   - FSM state enum
//   - size_decode(): funct3 + direction -> byte count, sign flag, legality
//   - byte_mask(): 8-lane mask covering the access within a two-word window
package lsu_pkg;

  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} lsu_state_e;

  typedef struct packed {
    logic [2:0] n;      // access size in bytes: 1, 2 or 4
    logic       sgn;    // sign-extend load result
    logic       legal;
  } size_dec_t;

  function automatic size_dec_t size_decode(input logic [2:0] funct3, input logic we);
    size_dec_t d;
    d.n     = 3'd1;
    d.sgn   = 1'b0;
    d.legal = 1'b0;
    case (funct3)
      Funct3B:  begin d.n = 3'd1; d.sgn = ~we; d.legal = 1'b1; end
      Funct3H:  begin d.n = 3'd2; d.sgn = ~we; d.legal = 1'b1; end
      Funct3W:  begin d.n = 3'd4; d.legal = 1'b1; end
      // Unsigned variants exist only for loads.
      Funct3Bu: begin d.n = 3'd1; d.legal = ~we; end
      Funct3Hu: begin d.n = 3'd2; d.legal = ~we; end
      default:  ;
    endcase
    return d;
  endfunction

  // Lanes 7:4 belong to the following word; any bit there means the access splits.
  function automatic logic [7:0] byte_mask(input logic [2:0] n, input logic [1:0] off);
    logic [7:0] base;
    case (n)
      3'd1:    base = 8'h01;
      3'd2:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// lsu_load_extract: combinational load-data extraction.
//   data_i   {hi, lo} two-word window as read from RAM
//   offset_i byte offset of the access within lo
//   size_i   access size in bytes (1, 2, 4)
//   sign_i   sign-extend when set, zero-extend otherwise
//   result_o right-justified, extended 32-bit load value
module lsu_load_extract (
  input  logic [63:0] data_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  // Shift in the full 64-bit context so hi bytes slide down, then keep the low word.
  assign shifted = 32'(data_i >> {offset_i, 3'b000});

  always_comb begin
    case (size_i)
      3'd1:    result_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
      3'd2:    result_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between RV32I execute and a byte-lane RAM.
// Accepts one byte-addressed access per handshake, drives word address, lane enables and
// lane-shifted store data, and returns extended load data with a one-cycle o_done pulse.
//
// Ports:
//   clk, rst (async, active-low), clk_en (low freezes all state)
//   i_req/o_ready handshake; i_we, i_funct3, i_addr, i_wdata request fields
//   o_done/o_rdata/o_fault registered completion
//   o_mem_* / i_mem_read_data RAM data port (combinational read)
//
// Build option: define LSU_MISALIGNED_EN to split word-crossing accesses into two RAM
// beats; without it such accesses complete with o_fault and no RAM activity.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 31,
  parameter int unsigned DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_req,
  output logic                  o_ready,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH:0]   i_addr,
  input  logic [DATA_WIDTH:0]   i_wdata,
  output logic                  o_done,
  output logic [DATA_WIDTH:0]   o_rdata,
  output logic                  o_fault,
  output logic                  o_mem_read_req,
  output logic [ADDR_WIDTH:0]   o_mem_read_addr,
  input  logic [DATA_WIDTH:0]   i_mem_read_data,
  output logic                  o_mem_write_enable,
  output logic [3:0]            o_mem_byte_enable,
  output logic [ADDR_WIDTH:0]   o_mem_write_addr,
  output logic [DATA_WIDTH:0]   o_mem_write_data
);

  localparam logic [ADDR_WIDTH:0] WordOne = 1;

  lsu_state_e state_q, state_d;

  size_dec_t dec;
  logic      accept, req_fault, split;
  logic [7:0] mask8;

  logic                  we_q, sgn_q;
  logic [2:0]            n_q;
  logic [1:0]            off_q;
  logic [ADDR_WIDTH:0]   word_q;
  logic [DATA_WIDTH:0]   wdata_q;
  logic                  done_q, fault_q;
  logic [DATA_WIDTH:0]   rdata_q, rdata_ext;
  logic [2*DATA_WIDTH+1:0] ld_data;
  logic [DATA_WIDTH:0]   st_lo;

  logic                in_beat;
  logic [ADDR_WIDTH:0] beat_word;
  logic [3:0]          beat_be;
  logic [DATA_WIDTH:0] beat_data;

  assign dec    = size_decode(i_funct3, i_we);
  assign accept = i_req && clk_en && (state_q == StIdle);
  assign mask8  = byte_mask(n_q, off_q);
  assign split  = |mask8[7:4];

`ifdef LSU_MISALIGNED_EN
  logic [DATA_WIDTH:0]     lo_q;
  logic [DATA_WIDTH:0]     st_hi;
  logic [2*DATA_WIDTH+1:0] st_data64;

  assign req_fault = ~dec.legal;
  assign st_data64 = {{(DATA_WIDTH+1){1'b0}}, wdata_q} << {off_q, 3'b000};
  assign st_lo     = st_data64[DATA_WIDTH:0];
  assign st_hi     = st_data64[2*DATA_WIDTH+1:DATA_WIDTH+1];
  // In ACC1 the live read data is the hi word; lo was captured at the end of ACC0.
  assign ld_data   = (state_q == StAcc1) ? {i_mem_read_data, lo_q}
                                         : {{(DATA_WIDTH+1){1'b0}}, i_mem_read_data};
`else
  logic [7:0] req_mask8;

  assign req_mask8 = byte_mask(dec.n, i_addr[1:0]);
  assign req_fault = ~dec.legal | (|req_mask8[7:4]);
  assign st_lo     = wdata_q << {off_q, 3'b000};
  assign ld_data   = {{(DATA_WIDTH+1){1'b0}}, i_mem_read_data};
`endif

  lsu_load_extract u_extract (
    .data_i   (ld_data),
    .offset_i (off_q),
    .size_i   (n_q),
    .sign_i   (sgn_q),
    .result_o (rdata_ext)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (clk_en) begin
      unique case (state_q)
        StIdle: if (i_req) state_d = req_fault ? StResp : StAcc0;
`ifdef LSU_MISALIGNED_EN
        StAcc0: state_d = split ? StAcc1 : StResp;
        StAcc1: state_d = StResp;
`else
        StAcc0: state_d = StResp;
`endif
        StResp: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic: RAM port is driven only while a beat is in progress.
  always_comb begin
    o_mem_read_req     = 1'b0;
    o_mem_read_addr    = '0;
    o_mem_write_enable = 1'b0;
    o_mem_byte_enable  = '0;
    o_mem_write_addr   = '0;
    o_mem_write_data   = '0;
    in_beat   = 1'b0;
    beat_word = word_q;
    beat_be   = mask8[3:0];
    beat_data = st_lo;
    case (state_q)
      StAcc0: in_beat = 1'b1;
`ifdef LSU_MISALIGNED_EN
      StAcc1: begin
        in_beat   = 1'b1;
        beat_word = word_q + WordOne;
        beat_be   = mask8[7:4];
        beat_data = st_hi;
      end
`endif
      default: ;
    endcase
    if (in_beat) begin
      if (we_q) begin
        o_mem_write_enable = 1'b1;
        o_mem_write_addr   = beat_word;
        o_mem_byte_enable  = beat_be;
        o_mem_write_data   = beat_data;
      end else begin
        o_mem_read_req  = 1'b1;
        o_mem_read_addr = beat_word;
      end
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_done  = done_q;
  assign o_fault = fault_q;
  assign o_rdata = rdata_q;

  // Request capture and registered completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      n_q     <= '0;
      off_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
`ifdef LSU_MISALIGNED_EN
      lo_q    <= '0;
`endif
    end else if (clk_en) begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      if (accept) begin
        we_q    <= i_we;
        sgn_q   <= dec.sgn;
        n_q     <= dec.n;
        off_q   <= i_addr[1:0];
        word_q  <= i_addr >> 2;
        wdata_q <= i_wdata;
        if (req_fault) begin
          done_q  <= 1'b1;
          fault_q <= 1'b1;
        end
      end
      if (state_q == StAcc0 && !split) begin
        done_q <= 1'b1;
        if (!we_q) rdata_q <= rdata_ext;
      end
`ifdef LSU_MISALIGNED_EN
      if (state_q == StAcc0) lo_q <= i_mem_read_data;
      if (state_q == StAcc1) begin
        done_q <= 1'b1;
        if (!we_q) rdata_q <= rdata_ext;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: randomized self-checking bench for lsu_align against a byte-level
// reference model (byte-addressed memory image, per-lane beat expectations).
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b1;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [2:0]  i_funct3 = 3'b0;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_wdata = 32'h0;
  logic        o_ready, o_done, o_fault;
  logic [31:0] o_rdata;
  logic        o_mem_read_req, o_mem_write_enable;
  logic [31:0] o_mem_read_addr, o_mem_write_addr, o_mem_write_data;
  logic [31:0] i_mem_read_data;
  logic [3:0]  o_mem_byte_enable;

  lsu_align #(
    .ADDR_WIDTH (31),
    .DATA_WIDTH (31)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .clk_en             (clk_en),
    .i_req              (i_req),
    .o_ready            (o_ready),
    .i_we               (i_we),
    .i_funct3           (i_funct3),
    .i_addr             (i_addr),
    .i_wdata            (i_wdata),
    .o_done             (o_done),
    .o_rdata            (o_rdata),
    .o_fault            (o_fault),
    .o_mem_read_req     (o_mem_read_req),
    .o_mem_read_addr    (o_mem_read_addr),
    .i_mem_read_data    (i_mem_read_data),
    .o_mem_write_enable (o_mem_write_enable),
    .o_mem_byte_enable  (o_mem_byte_enable),
    .o_mem_write_addr   (o_mem_write_addr),
    .o_mem_write_data   (o_mem_write_data)
  );

  always #5 clk = ~clk;

  // Bench RAM: 256 words, combinational read, lane writes gated on clk_en.
  logic [31:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_val = 32'h0;

  assign i_mem_read_data = mem[o_mem_read_addr[7:0]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (o_mem_write_enable && clk_en)
      for (int l = 0; l < 4; l++)
        if (o_mem_byte_enable[l])
          mem[o_mem_write_addr[7:0]][8*l +: 8] <= o_mem_write_data[8*l +: 8];
  end

  // Reference memory image, byte addressed (1 KiB wraps like the bench RAM).
  logic [7:0] ref_bytes [1024];

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Expectations for the transaction in flight.
  logic        exp_we, exp_fault;
  logic [31:0] exp_rdata;
  int          exp_done;
  logic [31:0] exp_word [2];
  logic [3:0]  exp_be   [2];
  logic [31:0] exp_wd   [2];

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    int n, off, k;
    bit legal, sgn, splits;
    logic [31:0] v;
    n      = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sgn    = !f3[2];
    off    = int'(addr % 4);
    splits = (off + n) > 4;
    exp_we    = we;
    exp_fault = !legal;
`ifndef LSU_MISALIGNED_EN
    if (splits) exp_fault = 1'b1;
`endif
    exp_done  = exp_fault ? 1 : (splits ? 3 : 2);
    exp_rdata = 32'h0;
    for (int b = 0; b < 2; b++) begin
      exp_word[b] = addr / 4 + b;
      exp_be[b]   = 4'h0;
      exp_wd[b]   = 32'h0;
      for (int l = 0; l < 4; l++) begin
        k = b * 4 + l - off;
        if (k >= 0 && k < n) exp_be[b][l] = 1'b1;
        if (k >= 0 && k < 4) exp_wd[b][8*l +: 8] = wd[8*k +: 8];
      end
    end
    if (!exp_fault && !we) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[(addr + i) % 1024];
      if (sgn) for (int j = 8 * n; j < 32; j++) v[j] = v[8*n-1];
      exp_rdata = v;
    end
  endtask

  task automatic check_cycle(input int c);
    if (c == exp_done) begin
      check_eq("resp_done", o_done, 1);
      check_eq("resp_fault", o_fault, exp_fault);
      check_eq("resp_rdata", o_rdata, exp_rdata);
      check_eq("resp_rd_req", o_mem_read_req, 0);
      check_eq("resp_wr_en", o_mem_write_enable, 0);
      check_eq("resp_ready", o_ready, 0);
    end else if (c > exp_done) begin
      check_eq("post_done", o_done, 0);
      check_eq("post_ready", o_ready, 1);
    end else begin
      check_eq("beat_done", o_done, 0);
      check_eq("beat_ready", o_ready, 0);
      if (exp_we) begin
        check_eq("st_wr_en", o_mem_write_enable, 1);
        check_eq("st_rd_req", o_mem_read_req, 0);
        check_eq("st_addr", o_mem_write_addr, exp_word[c-1]);
        check_eq("st_be", o_mem_byte_enable, exp_be[c-1]);
        check_eq("st_data", o_mem_write_data, exp_wd[c-1]);
      end else begin
        check_eq("ld_rd_req", o_mem_read_req, 1);
        check_eq("ld_wr_en", o_mem_write_enable, 0);
        check_eq("ld_addr", o_mem_read_addr, exp_word[c-1]);
      end
    end
  endtask

  // Starts and ends on a falling edge with the DUT idle.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input int stall_c, input int stall_n,
                            output logic [31:0] got_rdata);
    model(we, f3, addr, wd);
    got_rdata = 32'hx;
    check_eq("accept_ready", o_ready, 1);
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
    @(posedge clk);
    #1 i_req = 1'b0;
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      check_cycle(c);
      if (c == exp_done) got_rdata = o_rdata;
      if (c == stall_c) begin
        clk_en = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          check_cycle(c);
        end
        clk_en = 1'b1;
      end
    end
    if (we && !exp_fault) begin
      for (int i = 0; i < 4; i++)
        if ((i == 0) || (f3[1:0] == 2'd1 && i < 2) || f3[1:0] == 2'd2)
          ref_bytes[(addr + i) % 1024] = wd[8*i +: 8];
    end
  endtask

  task automatic set_word(input logic [7:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    for (int i = 0; i < 4; i++) ref_bytes[idx*4 + i] = val[8*i +: 8];
    @(negedge clk);
    pl_en = 1'b0;
  endtask

`ifdef LSU_MISALIGNED_EN
  localparam logic [31:0] RstAddr = 32'h0FE;
  localparam int          RstCyc  = 2;
`else
  localparam logic [31:0] RstAddr = 32'h100;
  localparam int          RstCyc  = 1;
`endif

  logic [31:0] r;

  initial begin
    @(negedge clk);
    for (int i = 0; i < 256; i++) set_word(i[7:0], $urandom);

    // Reset values while rst is held low.
    check_eq("rst_ready", o_ready, 1);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_fault", o_fault, 0);
    check_eq("rst_rdata", o_rdata, 0);
    check_eq("rst_rd_req", o_mem_read_req, 0);
    check_eq("rst_rd_addr", o_mem_read_addr, 0);
    check_eq("rst_wr_en", o_mem_write_enable, 0);
    check_eq("rst_be", o_mem_byte_enable, 0);
    check_eq("rst_wr_addr", o_mem_write_addr, 0);
    check_eq("rst_wr_data", o_mem_write_data, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases.
    set_word(8'h40, 32'hDEADBEEF);
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, r);
    check_eq("plan_lw", r, 32'hDEADBEEF);
    run_access(1'b1, 3'b000, 32'h103, 32'h000000AB, 0, 0, r);
    set_word(8'h40, 32'h80010000);
    run_access(1'b0, 3'b001, 32'h102, 32'h0, 0, 0, r);
    check_eq("plan_lh", r, 32'hFFFF8001);
    run_access(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, r);
    check_eq("plan_lhu", r, 32'h00008001);
    run_access(1'b1, 3'b010, 32'h0FE, 32'h11223344, 0, 0, r);
    run_access(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, r);
    run_access(1'b0, 3'b010, 32'h0FE, 32'h0, 0, 0, r);
    // clk_en low mid-access holds everything.
    run_access(1'b0, 3'b010, 32'h200, 32'h0, 1, 2, r);
    run_access(1'b1, 3'b001, 32'h203, 32'hCAFEF00D, 2, 3, r);
    run_access(1'b0, 3'b000, 32'h1FF, 32'h0, 1, 1, r);

    // Reset in the last beat of a load: no completion, no further beat.
    model(1'b0, 3'b010, RstAddr, 32'h0);
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = RstAddr;
    @(posedge clk);
    #1 i_req = 1'b0;
    for (int c = 1; c <= RstCyc; c++) @(negedge clk);
    check_eq("pre_rst_rd_req", o_mem_read_req, 1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_rd_req", o_mem_read_req, 0);
    check_eq("mid_rst_wr_en", o_mem_write_enable, 0);
    check_eq("mid_rst_ready", o_ready, 1);
    check_eq("mid_rst_done", o_done, 0);
    check_eq("mid_rst_rdata", o_rdata, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_done", o_done, 0);
      check_eq("post_rst_ready", o_ready, 1);
    end
    set_word(8'h41, 32'h0BADC0DE);
    run_access(1'b0, 3'b010, 32'h104, 32'h0, 0, 0, r);
    check_eq("post_rst_lw", r, 32'h0BADC0DE);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, wd;
      int          sc, sn;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom_range(0, 1023);
      wd   = $urandom;
      sc   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      sn   = int'($urandom_range(1, 3));
      run_access(we, f3, addr, wd, sc, sn, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit between the RV32I execute stage and the byte-lane `ram`. It accepts one byte-addressed load or store per handshake and decodes `funct3` into size and sign. It drives word addresses, byte enables and lane-shifted write data into the RAM's data port. On loads it returns sign- or zero-extended data, splitting accesses that cross a word boundary into two RAM beats.

## Interface
- `ADDR_WIDTH`, 31: MSB index of byte and word address buses (width = ADDR_WIDTH+1).
- `DATA_WIDTH`, 31: MSB index of data buses; fixed at 31 for RV32I.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `clk_en`  in  1  global enable; low freezes all state.
- `i_req`  in  1  access request from execute.
- `o_ready`  out  1  high only in IDLE; request accepted when `i_req && o_ready && clk_en`.
- `i_we`  in  1  1 = store, 0 = load.
- `i_funct3`  in  3  RV32I funct3.
- `i_addr`  in  ADDR_WIDTH+1  byte address.
- `i_wdata`  in  DATA_WIDTH+1  store data, right-justified.
- `o_done`  out  1  one-cycle completion pulse.
- `o_rdata`  out  DATA_WIDTH+1  load result, valid with `o_done`; 0 for stores and faults.
- `o_fault`  out  1  with `o_done`; set when funct3 is illegal or the access is misaligned and split is disabled.
- `o_mem_read_req`  out  1  RAM read request.
- `o_mem_read_addr`  out  ADDR_WIDTH+1  RAM word address.
- `i_mem_read_data`  in  DATA_WIDTH+1  RAM combinational read data.
- `o_mem_write_enable`  out  1  RAM write strobe.
- `o_mem_byte_enable`  out  4  RAM lane enables.
- `o_mem_write_addr`  out  ADDR_WIDTH+1  RAM word address.
- `o_mem_write_data`  out  DATA_WIDTH+1  lane-aligned store data.

## Operation
- Size decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 are illegal.
  - Stores: 000 SB, 001 SH, 010 SW; all other values are illegal.
- Request capture: on acceptance, latch addr, wdata, we, size n∈{1,2,4}, signed flag, offset = addr[1:0], and word = addr>>2 (zero-filled).
- Byte mask: mask8 = ((1<<n)-1) << offset. The access splits iff mask8[7:4] ≠ 0.
- Store data: data64 = {32'b0, wdata} << (8·offset).
  - Beat 0: word, be = mask8[3:0], data64[31:0].
  - Beat 1: word+1 (wraps to 0 at all-ones), be = mask8[7:4], data64[63:32].
- Load assembly:
  - Beat 0 data is captured into lo, beat 1 data into hi (hi = 0 if no split).
  - r = {hi, lo} >> (8·offset); keep the low n bytes, then sign-extend if the signed flag is set, else zero-extend.
- RAM port drive:
  - During a load beat, `o_mem_read_req` = 1, read address = beat word, and `o_mem_write_enable` = 0.
  - During a store beat, `o_mem_write_enable` = 1 and `o_mem_read_req` = 0.
  - Outside beats, all mem outputs are 0.
- State machine:
  - IDLE → ACC0 on accept. If illegal, or misaligned with split disabled, IDLE → RESP with fault set and no RAM activity.
  - ACC0 → ACC1 if the access splits, else → RESP.
  - ACC1 → RESP.
  - RESP → IDLE.
- Mid-operation events:
  - `rst` low at any time forces IDLE and zeroes all registers. A beat already issued is not undone, and no further beat is issued.
  - `clk_en` low holds state and registers. Mem outputs stay driven; the RAM gates its own writes on `clk_en`.

## Timing
- Reset values: `o_ready` = 1; all other outputs 0.
- Accept at cycle 0. ACC0 in cycle 1; load data is sampled at the end of ACC0.
  - Aligned access: `o_done` in cycle 2.
  - Split access: ACC1 in cycle 2, `o_done` in cycle 3.
  - Fault: `o_done` + `o_fault` in cycle 1.
- `o_rdata`, `o_done` and `o_fault` are registered and high for exactly one cycle.
- `o_ready` is low from cycle 1 until the cycle after RESP. Back-to-back accepts occur every 3 cycles for aligned accesses.

## Configuration
- `LSU_MISALIGNED_EN`:
  - Defined: word-crossing accesses split into two beats as above.
  - Undefined: any access with mask8[7:4] ≠ 0 completes with `o_fault` = 1, no RAM activity, and `o_rdata` = 0. The ACC1 state and the hi register are compiled out.

## Structure
- Package `lsu_pkg`:
  - funct3 localparams.
  - state enum {IDLE, ACC0, ACC1, RESP}.
  - Function `size_decode(funct3, we)` returning n, signed and legal.
- Sub-module `lsu_load_extract`: combinational {hi, lo}, offset, n, signed → 32-bit result.

## Test plan
- LW @0x100, RAM word 0x40 = 0xDEADBEEF → ACC0 read addr 0x40; `o_done` at cycle 2 with `o_rdata` = 0xDEADBEEF.
- SB @0x103, wdata 0x000000AB → write addr 0x40, be 4'b1000, data 0xAB000000; `o_done` at cycle 2.
- LH @0x102, word 0x80010000 → 0xFFFF8001; LHU at the same address → 0x00008001.
- With the macro defined, SW @0x0FE, wdata 0x11223344:
  - Beat 0: addr 0x3F, be 1100, data 0x33440000.
  - Beat 1: addr 0x40, be 0011, data 0x00001122.
  - `o_done` at cycle 3.
- Without the macro, the same access → `o_done` + `o_fault` at cycle 1 with no mem strobes. With either build, funct3 = 011 on a load → fault at cycle 1.
- `rst` low during ACC1 of a split load → outputs 0, `o_ready` = 1 next cycle, no `o_done`; a fresh LW then completes normally.
